ysyx_25020037_icache: RTL and testbench

- Direct-mapped instruction cache between the IFU and its AXI fetch path.
- Performs a combinational lookup on the IFU fetch address (`icache_addr`).
- On a miss it requests a block refill from the IFU (`mem_req`/`mem_addr`) and receives the block back on `mem_data`/`mem_ready`.
- Supports whole-cache invalidation for `fence.i` and keeps hit/miss performance counters.

---
 rtl/ysyx_25020037_icache.sv | 126 ++++++++++++
 tb/tb_ysyx_25020037_icache.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped instruction cache sitting between the IFU and its refill path.
// Zero-cycle hit lookup, block refill on miss, fence.i invalidate-all, hit/miss stats.
module ysyx_25020037_icache #(
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_LINES  = 16,
  parameter int OFFSET_W   = $clog2(BLOCK_SIZE),
  parameter int INDEX_W    = $clog2(NUM_LINES),
  parameter int TAG_W      = 32 - INDEX_W - OFFSET_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             icache_addr,
  output logic [31:0]             icache_data,
  output logic                    icache_hit,
  output logic                    icache_ready,
  input  logic                    access_en,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_data,
  input  logic                    mem_ready,
  input  logic                    fence_i,
  output logic                    flush_done,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int LINE_W = BLOCK_SIZE * 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MISS  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];

  logic [TAG_W-1:0]     tag;
  logic [INDEX_W-1:0]   idx;
  logic [LINE_W-1:0]    line;
  logic                 idle;
  logic                 fill;
  logic                 addr_unused;

  assign tag  = icache_addr[31 -: TAG_W];
  assign idx  = icache_addr[OFFSET_W +: INDEX_W];
  assign line = data_arr[idx];
  assign idle = (state == IDLE);
  assign fill = (state == MISS) & mem_ready;

  assign addr_unused = ^icache_addr[1:0];

  assign icache_ready = idle;
  assign flush_done   = (state == FLUSH);

  assign icache_hit = idle & valid[idx]
                    & (tag_arr[idx] == tag)
                    & ~fence_i;

  // A held mem_ready from the last refill must not start a new miss
  assign mem_req = idle & ~icache_hit
                 & ~fence_i & ~mem_ready;

  assign mem_addr = {icache_addr[31:OFFSET_W],
                     {OFFSET_W{1'b0}}};

  generate
    if (BLOCK_SIZE > 4) begin : g_sel
      logic [OFFSET_W-3:0] wsel;
      assign wsel = icache_addr[OFFSET_W-1:2];
      assign icache_data = line[{wsel, 5'd0} +: 32];
    end else begin : g_word
      assign icache_data = line[31:0];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fence_i)      state_nxt = FLUSH;
        else if (mem_req) state_nxt = MISS;
      end
      MISS:  if (mem_ready) state_nxt = IDLE;
      FLUSH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (state == FLUSH) begin
      valid <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (access_en & icache_hit) hit_cnt <= hit_cnt + 32'd1;
      if (mem_req) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// Self-checking bench for ysyx_25020037_icache.
// Line-level cache model plus directed refill/fence/reset scenarios.
module tb_ysyx_25020037_icache;

  logic        clk;
  logic        rst_n;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        icache_hit;
  logic        icache_ready;
  logic        access_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        fence_i;
  logic        flush_done;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int tests = 0;
  int fails = 0;

  ysyx_25020037_icache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_addr  (icache_addr),
    .icache_data  (icache_data),
    .icache_hit   (icache_hit),
    .icache_ready (icache_ready),
    .access_en    (access_en),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .fence_i      (fence_i),
    .flush_done   (flush_done),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: which lines hold which blocks, whether a refill
  // or an invalidate is pending, and how many hits/misses.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_refill;
  bit          m_flush;
  logic [31:0] m_hits;
  logic [31:0] m_miss;

  function automatic int lidx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic bit m_lookup(input logic [31:0] a);
    return m_valid[lidx(a)] && (m_tag[lidx(a)] == a[31:6]);
  endfunction

  function automatic bit e_ready();
    return !m_refill && !m_flush;
  endfunction

  function automatic bit e_hit();
    return e_ready() && !fence_i && m_lookup(icache_addr);
  endfunction

  function automatic bit e_req();
    return e_ready() && !e_hit() && !fence_i && !mem_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
      m_refill <= 1'b0;
      m_flush  <= 1'b0;
      m_hits   <= '0;
      m_miss   <= '0;
    end else if (m_flush) begin
      for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
      m_flush <= 1'b0;
    end else if (m_refill) begin
      if (mem_ready) begin
        m_valid[lidx(icache_addr)] <= 1'b1;
        m_tag[lidx(icache_addr)]   <= icache_addr[31:6];
        m_data[lidx(icache_addr)]  <= mem_data;
        m_refill <= 1'b0;
      end
    end else if (fence_i) begin
      m_flush <= 1'b1;
    end else if (e_hit()) begin
      if (access_en) m_hits <= m_hits + 32'd1;
    end else if (!mem_ready) begin
      m_refill <= 1'b1;
      m_miss   <= m_miss + 32'd1;
    end
  end

  always @(negedge clk) begin
    chk("hit", {31'd0, icache_hit}, {31'd0, e_hit()});
    chk("ready", {31'd0, icache_ready}, {31'd0, e_ready()});
    chk("mem_req", {31'd0, mem_req}, {31'd0, e_req()});
    chk("mem_addr", mem_addr, {icache_addr[31:2], 2'b00});
    chk("flush_done", {31'd0, flush_done}, {31'd0, m_flush});
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_miss);
    if (e_hit() && icache_hit)
      chk("data", icache_data, m_data[lidx(icache_addr)]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] a,
                        input logic [31:0] d,
                        input int dly,
                        input bit keep);
    int n = 0;
    icache_addr = a;
    #1;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("req_timeout", 32'd0, 32'd1);
    tick();
    repeat (dly - 1) tick();
    mem_data  = d;
    mem_ready = 1'b1;
    tick();
    if (!keep) mem_ready = 1'b0;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    icache_addr = 32'h3000_0000;
    access_en   = 1'b0;
    mem_data    = '0;
    mem_ready   = 1'b0;
    fence_i     = 1'b0;
    #2;
    chk("rst_hit", {31'd0, icache_hit}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd1);
    chk("rst_cnt", hit_cnt | miss_cnt, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;

    // cold miss
    chk("cold_req", {31'd0, mem_req}, 32'd1);
    chk("cold_addr", mem_addr, 32'h3000_0000);
    refill(32'h3000_0000, 32'h0010_0093, 3, 1'b0);
    chk("cold_miss", miss_cnt, 32'd1);
    chk("cold_hit", {31'd0, icache_hit}, 32'd1);
    chk("cold_data", icache_data, 32'h0010_0093);

    // repeat hit
    access_en = 1'b1;
    repeat (5) tick();
    access_en = 1'b0;
    #1;
    chk("rep_hits", hit_cnt, 32'd5);
    chk("rep_miss", miss_cnt, 32'd1);

    // conflict eviction on index 0
    refill(32'h3000_0040, 32'hDEAD_0040, 2, 1'b0);
    chk("conf_data", icache_data, 32'hDEAD_0040);
    icache_addr = 32'h3000_0000;
    #1;
    chk("conf_evict", {31'd0, icache_hit}, 32'd0);
    refill(32'h3000_0000, 32'h0010_0093, 1, 1'b1);
    chk("conf_miss", miss_cnt, 32'd3);

    // mem_ready held past the refill
    icache_addr = 32'h3000_0004;
    #1;
    chk("held_req0", {31'd0, mem_req}, 32'd0);
    tick();
    chk("held_req1", {31'd0, mem_req}, 32'd0);
    chk("held_miss", miss_cnt, 32'd3);
    mem_ready = 1'b0;
    #1;
    chk("held_rise", {31'd0, mem_req}, 32'd1);
    refill(32'h3000_0004, 32'h0020_8113, 2, 1'b0);
    chk("held_data", icache_data, 32'h0020_8113);
    icache_addr = 32'h3000_0000;
    #1;
    chk("held_keep", icache_data, 32'h0010_0093);

    // fence_i raised during a refill
    icache_addr = 32'h3000_0008;
    #1;
    tick();
    fence_i = 1'b1;
    repeat (2) tick();
    mem_data  = 32'h0030_0193;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("fen_idle", {31'd0, icache_ready}, 32'd1);
    chk("fen_mask", {31'd0, icache_hit}, 32'd0);
    tick();
    chk("fen_done", {31'd0, flush_done}, 32'd1);
    fence_i = 1'b0;
    tick();
    chk("fen_done0", {31'd0, flush_done}, 32'd0);
    chk("fen_inval", {31'd0, icache_hit}, 32'd0);
    chk("fen_req", {31'd0, mem_req}, 32'd1);
    chk("fen_miss", miss_cnt, 32'd5);

    // reset while refill is outstanding
    tick();
    chk("mid_busy", {31'd0, icache_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst", hit_cnt | miss_cnt, 32'd0);
    tick();
    rst_n     = 1'b1;
    mem_data  = 32'hBAD0_BAD0;
    mem_ready = 1'b1;
    #1;
    chk("late_req", {31'd0, mem_req}, 32'd0);
    chk("late_hit", {31'd0, icache_hit}, 32'd0);
    tick();
    chk("late_miss", miss_cnt, 32'd0);
    mem_ready = 1'b0;
    #1;
    chk("late_rise", {31'd0, mem_req}, 32'd1);
    refill(32'h3000_0008, 32'h0040_0213, 2, 1'b0);
    chk("late_data", icache_data, 32'h0040_0213);
    chk("late_cnt", miss_cnt, 32'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule
